// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: streams a WIDTH-bit operation LSB first through an
// external 1-bit ALU slice and assembles the result plus zero/carry/overflow.
//
// state | meaning
// IDLE  | ready for a command (start_ready=1)
// RUN   | one operand bit per clock through the slice
// DONE  | result and flags valid, waiting for out_ready
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             alu_in1,
  output logic             alu_in2,
  output logic             alu_carryIn,
  output logic             alu_ainvert,
  output logic             alu_binvert,
  output logic [1:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_carryOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [3:0]       ctrl_r;
  logic             cin_r;
  logic [CW-1:0]    cnt;
  logic             last_bit, is_arith, accept;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign is_arith = (ctrl_r[1:0] == 2'b10);
  assign accept   = (state == IDLE) && start_ready && start_valid;

  // zero is only meaningful alongside a valid result
  assign zero = out_valid & ~(|result);

  always_comb begin
    state_nxt   = state;
    alu_in1     = 1'b0;
    alu_in2     = 1'b0;
    alu_carryIn = 1'b0;
    alu_ainvert = 1'b0;
    alu_binvert = 1'b0;
    alu_op      = 2'b00;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        alu_in1     = a_sh[0];
        alu_in2     = b_sh[0];
        alu_carryIn = cin_r;
        alu_ainvert = ctrl_r[3];
        alu_binvert = ctrl_r[2];
        alu_op      = ctrl_r[1:0];
        if (last_bit) state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b0;
      out_valid   <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      ctrl_r      <= '0;
      cin_r       <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_ready <= (state_nxt == IDLE);
      out_valid   <= (state_nxt == DONE);
      if (accept) begin
        a_sh     <= a;
        b_sh     <= b;
        ctrl_r   <= ctrl;
        cin_r    <= ctrl[2];
        cnt      <= '0;
        result   <= '0;
        carry    <= 1'b0;
        overflow <= 1'b0;
      end else if (state == RUN) begin
        result <= {alu_result, result[WIDTH-1:1]};
        a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
        cin_r  <= is_arith & alu_carryOut;
        cnt    <= cnt + CW'(1);
        if (last_bit) begin
          carry    <= is_arith & alu_carryOut;
          overflow <= is_arith & (cin_r ^ alu_carryOut);
        end
      end
    end
  end

endmodule
